fp_accumulator: RTL and testbench

//  Streaming IEEE-754 single-precision accumulator built around the combinational Adder.

---
 rtl/fp_defs.sv | 10 +
 rtl/fp_accumulator_adder.sv | 54 +++++
 rtl/fp_accumulator.sv | 89 ++++++++
 tb/tb_fp_accumulator.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fp_defs.sv
// fp_defs: shared float field constants and accumulator state encoding
package fp_defs;
  localparam int FP_W = 32;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_OUT} state_e;
endpackage

// File: rtl/fp_accumulator_adder.sv
// fp_accumulator_adder: combinational IEEE-754 single add, round-to-nearest-even,
// o flags a finite sum that rounds past the largest normal
module fp_accumulator_adder
  import fp_defs::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result,
  output logic            o
);
  logic swap, sub, carry, rnd_up;
  logic [FP_W-1:0] x, y;
  logic [7:0] ex, ey, d, sh;
  logic [4:0] lz;
  logic [23:0] mx, my;
  logic [26:0] my_w, y_al, n;
  logic [27:0] sum;
  logic [8:0] ne, efield;
  logic [31:0] rnd;
  always_comb begin
    swap = b[FP_W-2:0] > a[FP_W-2:0];
    x = swap ? b : a;
    y = swap ? a : b;
    ex = (x[EXP_HI:EXP_LO] == 8'd0) ? 8'd1 : x[EXP_HI:EXP_LO];
    ey = (y[EXP_HI:EXP_LO] == 8'd0) ? 8'd1 : y[EXP_HI:EXP_LO];
    mx = {x[EXP_HI:EXP_LO] != 8'd0, x[EXP_LO-1:0]};
    my = {y[EXP_HI:EXP_LO] != 8'd0, y[EXP_LO-1:0]};
    d = ex - ey;
    my_w = {my, 3'b000};
    y_al = (my_w >> d) | {26'd0, |(my_w & ((27'd1 << d) - 27'd1))};
    sub = x[FP_W-1] ^ y[FP_W-1];
    sum = sub ? {1'b0, mx, 3'b000} - {1'b0, y_al} : {1'b0, mx, 3'b000} + {1'b0, y_al};
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    // normalisation stops at exponent 1 so tiny results land as subnormals
    sh = ({3'd0, lz} < ex) ? {3'd0, lz} : ex - 8'd1;
    carry = sum[27];
    n = carry ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
    ne = carry ? {1'b0, ex} + 9'd1 : {1'b0, ex - sh};
    efield = n[26] ? ne : 9'd0;
    rnd_up = n[2] & (|n[1:0] | n[3]);
    rnd = {efield, n[25:3]} + {31'd0, rnd_up};
    o = 1'b0;
    if (x[EXP_HI:EXP_LO] == EXP_SPECIAL)
      result = (x[EXP_LO-1:0] != '0 || (y[EXP_HI:EXP_LO] == EXP_SPECIAL && sub)) ? FP_QNAN : x;
    else if (sum == 28'd0)
      result = {x[FP_W-1] & y[FP_W-1], 31'd0};
    else if (rnd[31:23] >= 9'd255) begin
      result = {x[FP_W-1], EXP_SPECIAL, 23'd0};
      o = 1'b1;
    end else
      result = {x[FP_W-1], rnd[30:0]};
  end
endmodule

// File: rtl/fp_accumulator.sv
// fp_accumulator: streaming float vector summer, one element per two cycles
// through a single registered-operand adder slot
module fp_accumulator
  import fp_defs::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_cnt_sat,
  output logic             out_ovf,
  output logic             out_special
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_e state_q, state_d;
  logic [FP_W-1:0] acc_q, acc_d, op_q, op_d, add_res;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic last_q, last_d, cnt_sat_q, cnt_sat_d, ovf_q, ovf_d, special_q, special_d, add_ovf;
  fp_accumulator_adder u_add (.a(acc_q), .b(op_q), .result(add_res), .o(add_ovf));
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    op_d = op_q;
    last_d = last_q;
    cnt_d = cnt_q;
    cnt_sat_d = cnt_sat_q;
    ovf_d = ovf_q;
    special_d = special_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d = in_data;
        last_d = in_last;
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        cnt_sat_d = cnt_sat_q | (cnt_q == CNT_MAX);
        special_d = special_q | (in_data[EXP_HI:EXP_LO] == EXP_SPECIAL);
        state_d = S_ADD;
      end
      S_ADD: begin
        acc_d = add_res;
        ovf_d = ovf_q | add_ovf;
        state_d = last_q ? S_OUT : S_IDLE;
      end
      S_OUT: if (out_ready) begin
        acc_d = FP_POS_ZERO;
        cnt_d = '0;
        cnt_sat_d = 1'b0;
        ovf_d = 1'b0;
        special_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q <= FP_POS_ZERO;
      op_q <= '0;
      last_q <= 1'b0;
      cnt_q <= '0;
      cnt_sat_q <= 1'b0;
      ovf_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      op_q <= op_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      cnt_sat_q <= cnt_sat_d;
      ovf_q <= ovf_d;
      special_q <= special_d;
    end
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_OUT;
  assign out_sum = acc_q;
  assign out_count = cnt_q;
  assign out_cnt_sat = cnt_sat_q;
  assign out_ovf = ovf_q;
  assign out_special = special_q;
endmodule

// File: tb/tb_fp_accumulator.sv
// tb_fp_accumulator: directed and random vectors against an exact integer-sum model,
// with an 8-bit and a 2-bit counter instance sharing one stimulus stream
module tb_fp_accumulator;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic in_ready, in_ready2, out_valid, out_valid2;
  logic [31:0] out_sum, out_sum2;
  logic [7:0] out_count;
  logic [1:0] out_count2;
  logic sat, sat2, ovf, ovf2, spc, spc2;
  int checks = 0, failures = 0;
  int len, acc, x;

  always #5 clk = ~clk;

  fp_accumulator #(.CNT_W(8)) u8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_cnt_sat(sat), .out_ovf(ovf), .out_special(spc));
  fp_accumulator #(.CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_count(out_count2), .out_cnt_sat(sat2), .out_ovf(ovf2), .out_special(spc2));

  // exact float encoding of a small integer (|v| < 2**24)
  function automatic logic [31:0] i2f(input int v);
    int m, e;
    logic [31:0] mm;
    m = v < 0 ? -v : v;
    e = 0;
    if (m == 0) return 32'h0;
    while ((m >> (e + 1)) != 0) e++;
    mm = 32'(m) << (23 - e);
    return {v < 0, 8'(127 + e), mm[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_wait", {31'd0, in_ready}, 1);
    in_valid = 1; in_data = d; in_last = l;
    @(negedge clk);
    in_valid = 0; in_data = $urandom; in_last = 0;
    chk("in_ready_busy", {30'd0, in_ready2, in_ready}, 0);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] lo, input logic [31:0] hi,
                            input int cnt, input logic o, input logic s);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_valid"}, {30'd0, out_valid2, out_valid}, 3);
    checks++;
    assert (out_sum >= lo && out_sum <= hi && out_sum2 >= lo && out_sum2 <= hi) else begin
      failures++;
      $error("FAIL %s_sum observed=%h/%h expected=%h..%h", tag, out_sum, out_sum2, lo, hi);
    end
    chk({tag, "_cnt8"}, 32'(out_count), 32'(cnt > 255 ? 255 : cnt));
    chk({tag, "_cnt2"}, 32'(out_count2), 32'(cnt > 3 ? 3 : cnt));
    chk({tag, "_sat"}, {30'd0, sat2, sat}, {30'd0, cnt > 3, cnt > 255});
    chk({tag, "_flags"}, {28'd0, ovf2, ovf, spc2, spc}, {28'd0, o, o, s, s});
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 0);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_drop"}, {31'd0, out_valid}, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_sum", out_sum, 0);
    chk("rst_cnt", 32'(out_count), 0);
    rst_n = 1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge clk);

    send(32'h3F80_0000, 1);
    chk("lat_valid_early", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("lat_valid_on_time", {31'd0, out_valid}, 1);
    expect_out("single", 32'h3F80_0000, 32'h3F80_0000, 1, 0, 0);

    send(32'h3F80_0000, 0);
    send(32'hBF19_999A, 1);
    expect_out("two", 32'h3ECC_CCCC, 32'h3ECC_CCCD, 2, 0, 0);

    send(32'h4040_0000, 1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_sum", out_sum, 32'h4040_0000);
      chk("hold_ctl", {29'd0, out_valid, in_ready, out_count == 8'd1}, 3'b101);
      @(negedge clk);
    end
    expect_out("held", 32'h4040_0000, 32'h4040_0000, 1, 0, 0);
    send(32'h3F80_0000, 0);
    send(32'hC000_0000, 1);
    expect_out("restart", 32'hBF80_0000, 32'hBF80_0000, 2, 0, 0);

    for (int i = 0; i < 5; i++) send(32'h3F80_0000, i == 4);
    expect_out("five", 32'h40A0_0000, 32'h40A0_0000, 5, 0, 0);

    send(32'h7F7F_FFFF, 0);
    send(32'h7F7F_FFFF, 1);
    expect_out("ovf", 32'h7F80_0000, 32'h7F80_0000, 2, 1, 0);

    for (int v = 0; v < 15; v++) begin
      len = $urandom_range(1, 6);
      acc = 0;
      for (int k = 0; k < len; k++) begin
        x = int'($urandom_range(0, 2000)) - 1000;
        acc += x;
        send(i2f(x), k == len - 1);
      end
      expect_out("rand", i2f(acc), i2f(acc), len, 0, 0);
    end

    send(32'h3F80_0000, 0);
    send(32'h7F80_0000, 0);
    chk("inf_special", {31'd0, spc}, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_state", {29'd0, out_valid, spc, out_count != 0}, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_out", {31'd0, out_valid}, 0);
    end
    send(32'h4040_0000, 1);
    expect_out("after_rst", 32'h4040_0000, 32'h4040_0000, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
